// File: rtl/trace_ring_writer.sv
// ---------------------------------------------------------------------------
// trace_ring_writer
//
// Copies a 512-bit AXI-Stream trace feed into a ring buffer in host memory,
// one 64-byte AXI4 single-beat write per accepted stream beat. Software
// consumes entries and reports its position through sw_rd_ptr; the writer
// stalls (or drops, see below) when the ring is full. Only one AXI write is
// ever outstanding.
//
// Ports
//   aclk, areset             clock, synchronous active-high reset
//   s_axis_trace_*           incoming trace beats (tlast is ignored)
//   m_axi_aw* / m_axi_w*     single-beat INCR write, 64 bytes, at
//                            RING_BASE + wr_ptr*64
//   m_axi_b*                 write response; non-OKAY sets wr_err
//   sw_rd_ptr                software consumer index
//   wr_ptr                   next ring entry to be written
//   wr_err                   sticky write-error flag
//   drop_cnt                 saturating count of beats discarded while full
//
// Build option
//   TRACE_RING_DROP_EN  when defined, beats arriving while the ring is full
//                       are accepted and discarded (counted in drop_cnt)
//                       instead of being back-pressured. When undefined,
//                       drop_cnt is constant zero.
// ---------------------------------------------------------------------------
module trace_ring_writer #(
  parameter int unsigned       ADDR_W     = 36,
  parameter logic [ADDR_W-1:0] RING_BASE  = 36'h0,
  parameter int unsigned       RING_BEATS = 1024,
  localparam int unsigned      PW         = $clog2(RING_BEATS)
) (
  input  logic              aclk,
  input  logic              areset,

  input  logic              s_axis_trace_tvalid,
  output logic              s_axis_trace_tready,
  input  logic [511:0]      s_axis_trace_tdata,
  input  logic [63:0]       s_axis_trace_tkeep,
  input  logic              s_axis_trace_tlast,

  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,

  output logic [511:0]      m_axi_wdata,
  output logic [63:0]       m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,

  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,

  input  logic [PW-1:0]     sw_rd_ptr,
  output logic [PW-1:0]     wr_ptr,
  output logic              wr_err,
  output logic [31:0]       drop_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [1:0]    state_q,     state_d;
  logic [PW-1:0] wr_ptr_q,    wr_ptr_d;
  logic          wr_err_q,    wr_err_d;
  logic [511:0]  hold_data_q, hold_data_d;
  logic [63:0]   hold_keep_q, hold_keep_d;
  logic          awvalid_q,   awvalid_d;
  logic          wvalid_q,    wvalid_d;
`ifdef TRACE_RING_DROP_EN
  logic [31:0]   drop_cnt_q,  drop_cnt_d;
`endif

  logic [PW-1:0] wr_ptr_inc;
  logic          ring_full;
  logic          in_idle;
  logic          beat_acc;

  // Beats are written individually, so the packet boundary carries no meaning.
  logic unused_tlast;
  assign unused_tlast = s_axis_trace_tlast;

  // RING_BEATS is a power of two, so the PW-bit add wraps modulo the ring size.
  assign wr_ptr_inc = wr_ptr_q + PW'(1);

  // One slot is always left empty so that wr_ptr == sw_rd_ptr means empty.
  assign ring_full  = (wr_ptr_inc == sw_rd_ptr);
  assign in_idle    = (state_q == ST_IDLE);

`ifdef TRACE_RING_DROP_EN
  assign s_axis_trace_tready = in_idle && !areset;
`else
  assign s_axis_trace_tready = in_idle && !areset && !ring_full;
`endif

  assign beat_acc = s_axis_trace_tvalid && s_axis_trace_tready;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_err_d    = wr_err_q;
    hold_data_d = hold_data_q;
    hold_keep_d = hold_keep_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
`ifdef TRACE_RING_DROP_EN
    drop_cnt_d  = drop_cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (beat_acc) begin
          if (!ring_full) begin
            hold_data_d = s_axis_trace_tdata;
            hold_keep_d = s_axis_trace_tkeep;
            // Both channels raise together on entry to WRITE.
            awvalid_d   = 1'b1;
            wvalid_d    = 1'b1;
            state_d     = ST_WRITE;
          end
`ifdef TRACE_RING_DROP_EN
          else if (drop_cnt_q != '1) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
          end
`endif
        end
      end

      ST_WRITE: begin
        // AW and W retire independently; RESP is entered once both are done,
        // whether they completed in the same cycle or not.
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d)    state_d   = ST_RESP;
      end

      ST_RESP: begin
        if (m_axi_bvalid) begin
          // The entry is consumed even on error so the ring keeps moving.
          wr_ptr_d = wr_ptr_inc;
          wr_err_d = wr_err_q | (m_axi_bresp != 2'b00);
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      wr_err_q    <= 1'b0;
      hold_data_q <= '0;
      hold_keep_q <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
`ifdef TRACE_RING_DROP_EN
      drop_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_err_q    <= wr_err_d;
      hold_data_q <= hold_data_d;
      hold_keep_q <= hold_keep_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
`ifdef TRACE_RING_DROP_EN
      drop_cnt_q  <= drop_cnt_d;
`endif
    end
  end

  assign m_axi_awaddr  = RING_BASE + ADDR_W'({wr_ptr_q, 6'b0});
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'd6;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = awvalid_q;

  assign m_axi_wdata   = hold_data_q;
  assign m_axi_wstrb   = hold_keep_q;
  assign m_axi_wlast   = 1'b1;
  assign m_axi_wvalid  = wvalid_q;

  assign m_axi_bready  = (state_q == ST_RESP);

  assign wr_ptr        = wr_ptr_q;
  assign wr_err        = wr_err_q;
`ifdef TRACE_RING_DROP_EN
  assign drop_cnt      = drop_cnt_q;
`else
  assign drop_cnt      = '0;
`endif

endmodule

// File: tb/tb_trace_ring_writer.sv
// ---------------------------------------------------------------------------
// Bench for trace_ring_writer with a 4-entry ring at a non-zero base address.
// Inputs change 1 time unit after the rising edge; all sampling happens on
// the falling edge. Expected AW addresses and W payloads are queued when a
// beat is offered and retired by a monitor when the matching handshake is
// seen.
// ---------------------------------------------------------------------------
module tb_trace_ring_writer;

  localparam int unsigned  BEATS = 4;
  localparam logic [35:0]  BASE  = 36'h8_0000_1000;
`ifdef TRACE_RING_DROP_EN
  localparam logic         DROP  = 1'b1;
`else
  localparam logic         DROP  = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         areset = 1'b1;
  logic         tvalid = 1'b0;
  logic         tready;
  logic [511:0] tdata = '0;
  logic [63:0]  tkeep = '0;
  logic         tlast = 1'b0;
  logic [35:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic [1:0]   awburst;
  logic         awvalid;
  logic         awready = 1'b0;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready = 1'b0;
  logic [1:0]   bresp = 2'b00;
  logic         bvalid = 1'b0;
  logic         bready;
  logic [1:0]   sw_rd_ptr = '0;
  logic [1:0]   wr_ptr;
  logic         wr_err;
  logic [31:0]  drop_cnt;

  trace_ring_writer #(
    .ADDR_W     (36),
    .RING_BASE  (BASE),
    .RING_BEATS (BEATS)
  ) dut (
    .aclk                (clk),
    .areset              (areset),
    .s_axis_trace_tvalid (tvalid),
    .s_axis_trace_tready (tready),
    .s_axis_trace_tdata  (tdata),
    .s_axis_trace_tkeep  (tkeep),
    .s_axis_trace_tlast  (tlast),
    .m_axi_awaddr        (awaddr),
    .m_axi_awlen         (awlen),
    .m_axi_awsize        (awsize),
    .m_axi_awburst       (awburst),
    .m_axi_awvalid       (awvalid),
    .m_axi_awready       (awready),
    .m_axi_wdata         (wdata),
    .m_axi_wstrb         (wstrb),
    .m_axi_wlast         (wlast),
    .m_axi_wvalid        (wvalid),
    .m_axi_wready        (wready),
    .m_axi_bresp         (bresp),
    .m_axi_bvalid        (bvalid),
    .m_axi_bready        (bready),
    .sw_rd_ptr           (sw_rd_ptr),
    .wr_ptr              (wr_ptr),
    .wr_err              (wr_err),
    .drop_cnt            (drop_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_aw  = 0;
  int n_w   = 0;
  int n_b   = 0;
  int model_ptr = 0;

  logic [35:0]  q_aw[$];
  logic [575:0] q_w[$];

  function automatic void chk(input string nm, input logic [511:0] act,
                              input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: retire expectations on each handshake.
  always @(negedge clk) begin
    if (!areset) begin
      if (awvalid && awready) begin
        if (q_aw.size() == 0) begin
          chk("aw_unexpected", 1'b1, 1'b0);
        end else begin
          chk("awaddr", awaddr, q_aw.pop_front());
          chk("awlen", awlen, 8'd0);
          chk("awsize", awsize, 3'd6);
          chk("awburst", awburst, 2'b01);
        end
        n_aw++;
      end
      if (wvalid && wready) begin
        if (q_w.size() == 0) begin
          chk("w_unexpected", 1'b1, 1'b0);
        end else begin
          logic [575:0] e;
          e = q_w.pop_front();
          chk("wdata", wdata, e[511:0]);
          chk("wstrb", wstrb, e[575:512]);
          chk("wlast", wlast, 1'b1);
        end
        n_w++;
      end
      if (bvalid && bready) begin
        chk("b_after_aw_w", (n_aw == n_b + 1) && (n_w == n_b + 1), 1'b1);
        n_b++;
      end
    end
  end

  task automatic push_exp(input logic [511:0] d, input logic [63:0] k);
    q_aw.push_back(BASE + 36'(model_ptr * 64));
    q_w.push_back({k, d});
  endtask

  // Offer a beat and wait (bounded) until it is taken. Ends just before the
  // accepting edge.
  task automatic offer(input logic [511:0] d, input logic [63:0] k);
    int guard;
    tvalid = 1'b1;
    tdata  = d;
    tkeep  = k;
    tlast  = 1'b1;
    guard  = 0;
    @(negedge clk);
    while (!tready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("beat_accept", tready, 1'b1);
    push_exp(d, k);
  endtask

  // Full transaction: beat, AW/W with individual ready delays, then B.
  task automatic do_write(input logic [511:0] d, input logic [63:0] k,
                          input int aw_dly, input int w_dly, input int b_dly,
                          input logic [1:0] resp);
    int aw_hi;
    int w_hi;
    offer(d, k);
    tick();
    tvalid = 1'b0;
    aw_hi  = 0;
    w_hi   = 0;
    for (int c = 0; c < 40; c++) begin
      awready = (c >= aw_dly);
      wready  = (c >= w_dly);
      @(negedge clk);
      if (c == 0) chk("aw_w_together", {awvalid, wvalid}, 2'b11);
      if (awvalid) aw_hi++;
      if (wvalid)  w_hi++;
      if (bready && (awvalid || wvalid)) chk("bready_early", 1'b1, 1'b0);
      if (!awvalid && !wvalid) break;
      tick();
    end
    chk("write_phase_done", {awvalid, wvalid}, 2'b00);
    chk("awvalid_cycles", aw_hi, aw_dly + 1);
    chk("wvalid_cycles", w_hi, w_dly + 1);
    chk("bready_in_resp", bready, 1'b1);
    tick();
    awready = 1'b0;
    wready  = 1'b0;
    repeat (b_dly) tick();
    bvalid = 1'b1;
    bresp  = resp;
    tick();
    bvalid = 1'b0;
    bresp  = 2'b00;
    model_ptr = (model_ptr + 1) % BEATS;
  endtask

  task automatic reset_dut();
    areset  = 1'b1;
    tvalid  = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    sw_rd_ptr = '0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_tready", tready, 1'b0);
    chk("rst_wr_ptr", wr_ptr, 2'd0);
    chk("rst_wr_err", wr_err, 1'b0);
    chk("rst_drop_cnt", drop_cnt, 32'd0);
    chk("rst_valids", {awvalid, wvalid, bready}, 3'b000);
    tick();
    areset = 1'b0;
    model_ptr = 0;
    n_aw = 0;
    n_w  = 0;
    n_b  = 0;
    q_aw.delete();
    q_w.delete();
  endtask

  typedef struct {
    logic [511:0] data;
    logic [63:0]  keep;
    int           aw_dly;
    int           w_dly;
    int           b_dly;
    logic [1:0]   resp;
    logic [1:0]   exp_ptr;
    logic         exp_err;
  } vec_t;

  vec_t tab[5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tab[0] = '{{16{32'hA5A5_0001}}, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 2'b00, 2'd1, 1'b0};
    tab[1] = '{{16{32'h1234_5678}}, 64'h0000_0000_FFFF_00FF, 2, 0, 0, 2'b00, 2'd2, 1'b0};
    tab[2] = '{{8{64'hDEAD_BEEF_0BAD_F00D}}, 64'hF0F0_F0F0_0F0F_0F0F, 0, 2, 2, 2'b10, 2'd3, 1'b1};
    tab[3] = '{{16{32'h0000_FFFF}}, 64'h8000_0000_0000_0001, 1, 1, 0, 2'b00, 2'd0, 1'b1};
    tab[4] = '{{4{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210}}, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 2'b00, 2'd1, 1'b1};

    reset_dut();
    @(negedge clk);
    chk("idle_tready_empty", tready, 1'b1);
    tick();

    // Vectors: single writes with varied handshake timing and responses.
    for (int i = 0; i < 5; i++) begin
      sw_rd_ptr = 2'(model_ptr);
      do_write(tab[i].data, tab[i].keep, tab[i].aw_dly, tab[i].w_dly,
               tab[i].b_dly, tab[i].resp);
      @(negedge clk);
      chk($sformatf("vec%0d_wr_ptr", i), wr_ptr, tab[i].exp_ptr);
      chk($sformatf("vec%0d_wr_err", i), wr_err, tab[i].exp_err);
      tick();
    end

    // Reset while waiting for B: the write is abandoned.
    sw_rd_ptr = 2'(model_ptr);
    offer({16{32'h5555_AAAA}}, 64'h00FF_00FF_00FF_00FF);
    tick();
    tvalid  = 1'b0;
    awready = 1'b1;
    wready  = 1'b1;
    @(negedge clk);
    tick();
    awready = 1'b0;
    wready  = 1'b0;
    @(negedge clk);
    chk("resp_before_reset", bready, 1'b1);
    tick();
    areset = 1'b1;
    @(negedge clk);
    chk("tready_in_reset", tready, 1'b0);
    tick();
    areset    = 1'b0;
    sw_rd_ptr = '0;
    model_ptr = 0;
    n_aw = 0;
    n_w  = 0;
    n_b  = 0;
    @(negedge clk);
    chk("abort_bready", bready, 1'b0);
    chk("abort_wr_ptr", wr_ptr, 2'd0);
    chk("abort_wr_err", wr_err, 1'b0);
    chk("abort_valids", {awvalid, wvalid}, 2'b00);
    chk("abort_tready", tready, 1'b1);
    tick();
    do_write({16{32'hCAFE_0000}}, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 2'b00);
    @(negedge clk);
    chk("post_abort_wr_ptr", wr_ptr, 2'd1);
    tick();

    // Fill a 4-entry ring, stall (or drop), then free space and wrap.
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      do_write({16{32'hF000_0000 + 32'(i)}}, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 2'b00);
    end
    @(negedge clk);
    chk("fill_wr_ptr", wr_ptr, 2'd3);
    tick();
`ifdef TRACE_RING_DROP_EN
    tvalid = 1'b1;
    tdata  = {16{32'hD0D0_D0D0}};
    tkeep  = '1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("drop_tready", tready, 1'b1);
      chk("drop_no_aw", awvalid, 1'b0);
      tick();
    end
    tvalid = 1'b0;
    @(negedge clk);
    chk("drop_cnt", drop_cnt, 32'd10);
    chk("drop_wr_ptr", wr_ptr, 2'd3);
    tick();
`else
    tvalid = 1'b1;
    tdata  = {16{32'hF000_0003}};
    tkeep  = '1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_tready", tready, 1'b0);
      chk("full_no_aw", awvalid, 1'b0);
      tick();
    end
    tvalid = 1'b0;
    @(negedge clk);
    chk("full_drop_cnt", drop_cnt, 32'd0);
    tick();
`endif
    sw_rd_ptr = 2'd2;
    @(negedge clk);
    chk("space_tready", tready, 1'b1);
    tick();
    do_write({16{32'hF000_0003}}, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 2'b00);
    do_write({16{32'hF000_0004}}, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 2'b00);
    @(negedge clk);
    chk("wrap_wr_ptr", wr_ptr, 2'd1);
    chk("wrap_full_tready", tready, DROP);
    chk("wrap_wr_err", wr_err, 1'b0);
    tick();

    chk("aw_queue_drained", q_aw.size(), 0);
    chk("w_queue_drained", q_w.size(), 0);
    chk("b_count", n_b, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
